// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file access arbiter:
//   - register file operation codes driven on rf_op_code
//   - arbiter FSM state encoding
//   - default register file geometry (WORDSIZE x SIZE)
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int WORDSIZE_DEF = 64;
  localparam int SIZE_DEF     = 32;

  localparam logic [6:0] OP_NOP   = 7'b0000000;
  localparam logic [6:0] OP_STORE = 7'b0000001;
  localparam logic [6:0] OP_LOAD  = 7'b0000010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage : regfile_pkg

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way grant.
//   valid_i[1:0]   request valid per requester
//   last_grant_i   previous winner (round-robin build only)
//   grant_o[1:0]   one-hot grant, zero when nothing is valid
// Build option: REGFILE_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// always wins a tie) and removes the last_grant_i port.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  output logic [1:0] grant_o,
`ifndef REGFILE_ARB_FIXED_PRIO_EN
  input  logic       last_grant_i,
`endif
  input  logic [1:0] valid_i
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      grant_o = 2'b01;
`else
      // On a tie the requester that did not win last time goes first.
      grant_o = last_grant_i ? 2'b01 : 2'b10;
`endif
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_access_arbiter
// Shares the single access port of the processor register file between two
// requesters (0 = execute unit, 1 = load/debug unit). One access is in flight
// at a time: accept (IDLE) -> drive register file (ISSUE) -> respond (RESP).
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]  per-requester handshake (ready only in IDLE)
//   req_we[1:0]               per-requester write enable
//   req_addr[2*ADDR_W-1:0]    requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata[2*WORDSIZE-1:0] requester i at [i*WORDSIZE +: WORDSIZE]
//   resp_valid[1:0]           one-cycle response pulse to the owner
//   resp_rdata                read data (0 for writes)
//   rf_rs1/rf_rd_in/rf_op_code register file controls, non-NOP only in ISSUE
//   rf_rs1_out                register file read data
//
// Build option: REGFILE_ARB_FIXED_PRIO_EN -> fixed priority to requester 0,
// no last-grant state.
// -----------------------------------------------------------------------------
module regfile_access_arbiter
  import regfile_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF,
  parameter int SIZE     = SIZE_DEF,
  parameter int ADDR_W   = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*WORDSIZE-1:0] req_wdata,
  output logic [1:0]            resp_valid,
  output logic [WORDSIZE-1:0]   resp_rdata,
  output logic [ADDR_W-1:0]     rf_rs1,
  output logic [WORDSIZE-1:0]   rf_rd_in,
  output logic [6:0]            rf_op_code,
  input  logic [WORDSIZE-1:0]   rf_rs1_out
);

  arb_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORDSIZE-1:0]   wdata_q, wdata_d;
  logic                  winner_q, winner_d;
  logic [WORDSIZE-1:0]   rdata_q, rdata_d;
  logic [1:0]            grant;
  logic                  addr_live;

  logic [ADDR_W-1:0]     addr_arr  [2];
  logic [WORDSIZE-1:0]   wdata_arr [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*WORDSIZE +: WORDSIZE];
  end

  // Register 0 is hardwired to zero; addresses past the end of the file
  // behave the same way.
  assign addr_live = (addr_q != '0) && (int'(addr_q) < SIZE);

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  rr_arbiter2 u_arb (
    .grant_o (grant),
    .valid_i (req_valid)
  );
`else
  logic last_grant_q, last_grant_d;

  rr_arbiter2 u_arb (
    .grant_o      (grant),
    .last_grant_i (last_grant_q),
    .valid_i      (req_valid)
  );

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      winner_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      winner_q <= winner_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    winner_d   = winner_q;
    rdata_d    = rdata_q;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_rdata = '0;
    rf_rs1     = '0;
    rf_rd_in   = '0;
    rf_op_code = OP_NOP;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          // The state register is already forced to IDLE while rst_n is low;
          // gating here keeps req_ready low during reset as well.
          req_ready = grant & {2{rst_n}};
          winner_d  = grant[1];
          we_d      = req_we[grant[1]];
          addr_d    = addr_arr[grant[1]];
          wdata_d   = wdata_arr[grant[1]];
`ifndef REGFILE_ARB_FIXED_PRIO_EN
          last_grant_d = grant[1];
`endif
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        rf_rs1 = addr_q;
        if (we_q) begin
          rf_rd_in   = wdata_q;
          rf_op_code = addr_live ? OP_STORE : OP_NOP;
        end else begin
          rf_op_code = OP_LOAD;
        end
        // Read data is captured here so RESP does not depend on what the
        // register file shows once its inputs return to idle.
        rdata_d = (!we_q && addr_live) ? rf_rs1_out : '0;
        state_d = RESP;
      end

      RESP: begin
        resp_valid[winner_q] = 1'b1;
        resp_rdata           = rdata_q;
        state_d              = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : regfile_access_arbiter

// File: tb/tb_regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_arbiter
// Drives the arbiter with directed and random requests, emulates the register
// file it controls, and compares every cycle against a timeline model of the
// expected accept / issue / response behaviour.
// -----------------------------------------------------------------------------
module tb_regfile_access_arbiter;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic [AW-1:0]   rf_rs1;
  logic [DW-1:0]   rf_rd_in;
  logic [6:0]      rf_op_code;
  logic [DW-1:0]   rf_rs1_out;

  always #5 clk = ~clk;

  regfile_access_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .rf_rs1     (rf_rs1),
    .rf_rd_in   (rf_rd_in),
    .rf_op_code (rf_op_code),
    .rf_rs1_out (rf_rs1_out)
  );

  // Register file emulation; location 0 shows garbage so the arbiter's own
  // zeroing of register 0 is exercised.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_op_code == OP_STORE) rf_mem[rf_rs1] <= rf_rd_in;
  end
  assign rf_rs1_out = (rf_rs1 == '0) ? 64'hDEAD_BEEF_CAFE_F00D : rf_mem[rf_rs1];

  // Reference model: expected contents plus a timeline of the access in flight.
  logic [DW-1:0] ref_mem [32];
  int            cyc = 0;
  int            free_cyc = 0;
  int            issue_cyc = -1;
  int            resp_cyc = -1;
  int            last_win = 1;
  int            cur_win = 0;
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  bit            accepted = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    if (v == 2'b11) return 1 - last_win;
    return v[0] ? 0 : 1;
`endif
  endfunction

  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [1:0]    exp_ready;
    logic [1:0]    exp_resp;
    logic [6:0]    exp_op;
    logic [DW-1:0] exp_data;
    int            w;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    exp_ready = 2'b00;
    w = 0;
    if (cyc >= free_cyc && v != 2'b00) begin
      w = pick(v);
      exp_ready[w] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);

    if (cyc == issue_cyc) begin
      exp_op = cur_we ? ((cur_addr != 0) ? OP_STORE : OP_NOP) : OP_LOAD;
      check("issue_op", rf_op_code, exp_op);
      check("issue_rs1", rf_rs1, cur_addr);
      check("issue_rd_in", rf_rd_in, cur_we ? cur_wdata : '0);
      if (cur_we && cur_addr != 0) ref_mem[cur_addr] = cur_wdata;
    end else begin
      check("idle_op", rf_op_code, OP_NOP);
      check("idle_rs1", rf_rs1, '0);
      check("idle_rd_in", rf_rd_in, '0);
    end

    if (cyc == resp_cyc) begin
      exp_resp = 2'b00;
      exp_resp[cur_win] = 1'b1;
      exp_data = (cur_we || cur_addr == 0) ? '0 : ref_mem[cur_addr];
      check("resp_valid", resp_valid, exp_resp);
      check("resp_rdata", resp_rdata, exp_data);
      $display("txn R%0d %s addr=%0d data=%h", cur_win, cur_we ? "WR" : "RD",
               cur_addr, cur_we ? cur_wdata : resp_rdata);
    end else begin
      check("no_resp", resp_valid, 2'b00);
    end

    accepted = 1'b0;
    if (exp_ready != 2'b00) begin
      cur_win   = w;
      cur_we    = we[w];
      cur_addr  = (w == 1) ? a1 : a0;
      cur_wdata = (w == 1) ? d1 : d0;
      last_win  = w;
      issue_cyc = cyc + 1;
      resp_cyc  = cyc + 2;
      free_cyc  = cyc + 3;
      accepted  = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  // Hold a single request until it is accepted, bounded.
  task automatic request(input int r, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    int n;
    n = 0;
    do begin
      step((r == 0) ? 2'b01 : 2'b10, {we, we}, a, a, d, d);
      n++;
    end while (!accepted && n < 10);
    check("accept_in_time", accepted, 1'b1);
  endtask

  // Reset with both requesters pending: everything must read zero.
  task automatic rst_pulse(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_we    = 2'b11;
      #1;
      check("rst_ready", req_ready, 2'b00);
      check("rst_resp_valid", resp_valid, 2'b00);
      check("rst_resp_rdata", resp_rdata, '0);
      check("rst_op", rf_op_code, OP_NOP);
      check("rst_rs1", rf_rs1, '0);
      check("rst_rd_in", rf_rd_in, '0);
      cyc++;
    end
    req_valid = 2'b00;
    rst_n     = 1'b1;
    free_cyc  = cyc;
    issue_cyc = -1;
    resp_cyc  = -1;
    last_win  = 1;
  endtask

  initial begin
    rst_pulse(3);

    // Write then read register 4.
    request(0, 1'b1, 5'd4, 64'h0000_0000_5f11_e01a);
    idle(2);
    request(1, 1'b0, 5'd4, '0);
    idle(2);

    // Both requesters continuously valid from reset.
    rst_pulse(2);
    for (int k = 0; k < 12; k++) step(2'b11, 2'b00, 5'd4, 5'd4, '0, '0);
    idle(2);

    // Register 0: write dropped, read returns zero.
    request(0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(2);
    request(0, 1'b0, 5'd0, '0);
    idle(2);

    // Give every register a known value.
    for (int a = 1; a < 32; a++) begin
      request(0, 1'b1, 5'(a), {$urandom, $urandom});
      idle(2);
    end

    // Reset during the ISSUE cycle of a requester-1 read.
    request(1, 1'b0, 5'd7, '0);
    rst_pulse(2);
    for (int k = 0; k < 6; k++) step(2'b11, 2'b00, 5'd9, 5'd10, '0, '0);
    idle(2);

    // Requester 1 pulses valid only while busy: must be ignored.
    request(0, 1'b0, 5'd3, '0);
    step(2'b10, 2'b11, 5'd0, 5'd9, '0, 64'h1234);
    idle(4);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_access_arbiter
